aibcr3_rxdig_deser: RTL and testbench

- Parametrised multi-lane RX deserializer and word aligner for the AIB receive path.
- Sits after the per-pad RX capture cells, in the iclkin_dist domain.
- Takes each lane's retimed bit pair (odat0/odat1) every cycle and packs the bits into WORD_W-bit words.
- Supports DDR and SDR modes decoded from irxen, plus per-lane bit-slip alignment, which the single-bit capture cell does not provide.

---
 rtl/aibcr3_rxdig_deser.sv | 134 +++++++++++++
 tb/tb_aibcr3_rxdig_deser.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/aibcr3_rxdig_deser.sv
// AIB RX deserializer / word aligner.
// Each lane packs its retimed odat0/odat1 stream into WORD_W-bit words, LSB first.
// It supports DDR and SDR modes and per-lane bit-slip alignment.

module aibcr3_rxdig_deser_lane #(
  parameter int WORD_W = 8
) (
  input  logic              iclkin_dist,
  input  logic              irstb,
  input  logic              clr,
  input  logic              cap,
  input  logic              ddr,
  input  logic              d0,
  input  logic              d1,
  input  logic              slip,
  output logic [WORD_W-1:0] dout,
  output logic              dout_vld
);
  localparam int CW = $clog2(WORD_W) + 1;
  localparam logic [CW-1:0] WCNT = CW'(WORD_W);

  logic [CW-1:0]     cnt;
  logic [CW-1:0]     sum;
  logic [CW-1:0]     nadd;
  logic [1:0]        nb;
  logic [WORD_W-1:0] sr;
  logic [WORD_W:0]   acc;

  // New bits for this cycle, oldest at bit 0; a slip drops odat0
  always_comb begin
    nb   = 2'b00;
    nadd = '0;
    if (ddr) begin
      if (slip) begin
        nb   = {1'b0, d1};
        nadd = CW'(1);
      end else begin
        nb   = {d1, d0};
        nadd = CW'(2);
      end
    end else if (!slip) begin
      nb   = {1'b0, d0};
      nadd = CW'(1);
    end
    sum = cnt + nadd;
    acc = {1'b0, sr} | ({{(WORD_W-1){1'b0}}, nb} << cnt);
  end

  // Accumulate bits; emit a word when WORD_W are held, carrying any overflow bit
  always_ff @(posedge iclkin_dist or negedge irstb) begin
    if (!irstb) begin
      cnt      <= '0;
      sr       <= '0;
      dout     <= '0;
      dout_vld <= 1'b0;
    end else if (clr) begin
      cnt      <= '0;
      sr       <= '0;
      dout     <= '0;
      dout_vld <= 1'b0;
    end else if (cap) begin
      if (sum >= WCNT) begin
        dout     <= acc[WORD_W-1:0];
        sr       <= {{(WORD_W-1){1'b0}}, acc[WORD_W]};
        cnt      <= sum - WCNT;
        dout_vld <= 1'b1;
      end else begin
        sr       <= acc[WORD_W-1:0];
        cnt      <= sum;
        dout_vld <= 1'b0;
      end
    end else begin
      dout_vld <= 1'b0;
    end
  end
endmodule

module aibcr3_rxdig_deser #(
  parameter int NLANE = 4,
  parameter int RATIO = 4
) (
  input  logic                      iclkin_dist,
  input  logic                      irstb,
  input  logic [2:0]                irxen,
  input  logic [NLANE-1:0]          odat0,
  input  logic [NLANE-1:0]          odat1,
  input  logic [NLANE-1:0]          bitslip,
  output logic [NLANE*2*RATIO-1:0]  dout,
  output logic [NLANE-1:0]          dout_vld,
  output logic                      mode_ddr,
  output logic                      mode_sdr,
  output logic                      mode_off
);
  localparam int WORD_W = 2 * RATIO;
  localparam logic [2:0] M_DDR = 3'b001;
  localparam logic [2:0] M_SDR = 3'b100;
  localparam logic [2:0] M_OFF = 3'b010;

  logic [2:0] mode_q;
  logic       cap;
  logic       clr;
  logic [NLANE-1:0][WORD_W-1:0] dout_l;

  // Mode register follows irxen every cycle; a mismatch marks a change cycle
  always_ff @(posedge iclkin_dist or negedge irstb) begin
    if (!irstb) mode_q <= M_OFF;
    else        mode_q <= irxen;
  end

  assign mode_ddr = (mode_q == M_DDR);
  assign mode_sdr = (mode_q == M_SDR);
  assign mode_off = !(mode_ddr || mode_sdr);

  // Capture only in a settled active mode; change cycles and off mode clear the lanes
  assign cap = !mode_off && (irxen == mode_q);
  assign clr = !cap;

  for (genvar i = 0; i < NLANE; i++) begin : g_lane
    aibcr3_rxdig_deser_lane #(.WORD_W(WORD_W)) u_lane (
      .iclkin_dist (iclkin_dist),
      .irstb       (irstb),
      .clr         (clr),
      .cap         (cap),
      .ddr         (mode_ddr),
      .d0          (odat0[i]),
      .d1          (odat1[i]),
      .slip        (bitslip[i]),
      .dout        (dout_l[i]),
      .dout_vld    (dout_vld[i])
    );
  end

  assign dout = dout_l;
endmodule

// File: tb/tb_aibcr3_rxdig_deser.sv
// Bench for aibcr3_rxdig_deser: directed scenarios plus randomized traffic.
// Expected values come from a per-lane bit-queue reference model.

module tb_aibcr3_rxdig_deser;
  localparam int NLANE = 4;
  localparam int RATIO = 4;
  localparam int W     = 2 * RATIO;

  logic                 clk;
  logic                 irstb;
  logic [2:0]           irxen;
  logic [NLANE-1:0]     odat0, odat1, bitslip;
  logic [NLANE*W-1:0]   dout;
  logic [NLANE-1:0]     dout_vld;
  logic                 mode_ddr, mode_sdr, mode_off;

  int checks = 0;
  int failures = 0;

  // Reference model state
  bit                   q[NLANE][$];
  logic [2:0]           m_mode;
  logic [NLANE-1:0][W-1:0] e_dout;
  logic [NLANE-1:0]     e_vld;

  aibcr3_rxdig_deser #(.NLANE(NLANE), .RATIO(RATIO)) dut (
    .iclkin_dist (clk),
    .irstb       (irstb),
    .irxen       (irxen),
    .odat0       (odat0),
    .odat1       (odat1),
    .bitslip     (bitslip),
    .dout        (dout),
    .dout_vld    (dout_vld),
    .mode_ddr    (mode_ddr),
    .mode_sdr    (mode_sdr),
    .mode_off    (mode_off)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NLANE; i++) q[i].delete();
    m_mode = 3'b010;
    e_dout = '0;
    e_vld  = '0;
  endtask

  // One clock edge of the spec's behaviour, applied to the currently driven inputs
  task automatic model_step();
    bit active;
    if (!irstb) begin
      model_reset();
      return;
    end
    active = (m_mode == 3'b001 || m_mode == 3'b100) && (irxen == m_mode);
    if (!active) begin
      for (int i = 0; i < NLANE; i++) q[i].delete();
      e_dout = '0;
      e_vld  = '0;
    end else begin
      for (int i = 0; i < NLANE; i++) begin
        if (!bitslip[i]) q[i].push_back(odat0[i]);
        if (m_mode == 3'b001) q[i].push_back(odat1[i]);
        e_vld[i] = 1'b0;
        if (q[i].size() >= W) begin
          for (int b = 0; b < W; b++) e_dout[i][b] = q[i].pop_front();
          e_vld[i] = 1'b1;
        end
      end
    end
    m_mode = irxen;
  endtask

  task automatic compare();
    logic [2:0] ef;
    ef[2] = (m_mode == 3'b001);
    ef[1] = (m_mode == 3'b100);
    ef[0] = !(ef[2] || ef[1]);
    for (int i = 0; i < NLANE; i++) chk($sformatf("dout_l%0d", i), 32'(dout[i*W +: W]), 32'(e_dout[i]));
    chk("dout_vld", 32'(dout_vld), 32'(e_vld));
    chk("mode", 32'({mode_ddr, mode_sdr, mode_off}), 32'(ef));
  endtask

  // Drive one cycle at the falling edge, then check #1 after the rising edge
  task automatic cycle(input logic [2:0] rx, input logic [NLANE-1:0] d0, input logic [NLANE-1:0] d1,
                       input logic [NLANE-1:0] sl);
    @(negedge clk);
    irxen = rx; odat0 = d0; odat1 = d1; bitslip = sl;
    model_step();
    @(posedge clk);
    #1;
    compare();
  endtask

  logic [7:0] pat0, pat1;
  logic [7:0] sdr_pat;
  logic [7:0] last0;

  initial begin
    // Test 1: reset with random inputs
    irstb = 1'b0;
    irxen = 3'($urandom); odat0 = 4'($urandom); odat1 = 4'($urandom); bitslip = 4'($urandom);
    model_reset();
    #12;
    chk("rst_dout", dout, 32'h0);
    chk("rst_vld", 32'(dout_vld), 32'h0);
    chk("rst_off", 32'(mode_off), 32'h1);
    @(posedge clk); #1;
    irstb = 1'b1;
    cycle(3'b010, 4'($urandom), 4'($urandom), 4'($urandom));
    cycle(3'b010, 4'($urandom), 4'($urandom), 4'($urandom));

    // Test 2: DDR word 0x4D on lane 0
    pat0 = 8'b0100_1101;
    cycle(3'b001, 4'($urandom), 4'($urandom), 4'h0);
    for (int c = 0; c < 4; c++)
      cycle(3'b001, {3'($urandom), pat0[2*c]}, {3'($urandom), pat0[2*c+1]}, 4'h0);
    chk("ddr_4d", 32'(dout[7:0]), 32'h4D);
    chk("ddr_4d_vld", 32'(dout_vld[0]), 32'h1);
    cycle(3'b001, 4'($urandom), 4'($urandom), 4'h0);
    chk("ddr_vld_1cyc", 32'(dout_vld[0]), 32'h0);

    // Test 3: SDR word 0x0F
    sdr_pat = 8'h0F;
    cycle(3'b100, 4'($urandom), 4'($urandom), 4'h0);
    for (int c = 0; c < 8; c++) begin
      cycle(3'b100, {3'($urandom), sdr_pat[c]}, 4'(c[0] ? 4'hF : 4'h0), 4'h0);
      if (c == 3) chk("sdr_no_vld4", 32'(dout_vld[0]), 32'h0);
    end
    chk("sdr_0f", 32'(dout[7:0]), 32'h0F);
    chk("sdr_vld", 32'(dout_vld[0]), 32'h1);

    // Test 4: bit-slip in DDR, lanes 0/1 fed constant (1,0)
    cycle(3'b001, 4'h3, 4'h0, 4'h0);
    for (int c = 0; c < 4; c++) cycle(3'b001, 4'h3, 4'h0, 4'h0);
    chk("slip_pre55", 32'(dout[7:0]), 32'h55);
    cycle(3'b001, 4'h3, 4'h0, 4'h1);
    last0 = 8'h00;
    for (int c = 0; c < 12; c++) begin
      cycle(3'b001, 4'h3, 4'h0, 4'h0);
      if (dout_vld[0]) last0 = dout[7:0];
    end
    chk("slip_aa", 32'(last0), 32'hAA);
    chk("slip_l1_55", 32'(dout[15:8]), 32'h55);

    // Test 5: mode change mid-word
    cycle(3'b001, 4'($urandom), 4'($urandom), 4'h0);
    cycle(3'b001, 4'hF, 4'hF, 4'h0);
    cycle(3'b001, 4'hF, 4'hF, 4'h0);
    cycle(3'b010, 4'($urandom), 4'($urandom), 4'h0);
    chk("chg_off", 32'(mode_off), 32'h1);
    chk("chg_dout0", dout, 32'h0);
    cycle(3'b001, 4'($urandom), 4'($urandom), 4'h0);
    for (int c = 0; c < 4; c++) cycle(3'b001, {3'h0, pat0[2*c]}, {3'h0, pat0[2*c+1]}, 4'h0);
    chk("chg_4d", 32'(dout[7:0]), 32'h4D);

    // Test 6: async reset mid-word
    for (int c = 0; c < 3; c++) cycle(3'b001, 4'hF, 4'hF, 4'h0);
    #2 irstb = 1'b0;
    #1;
    model_reset();
    chk("arst_dout", dout, 32'h0);
    chk("arst_vld", 32'(dout_vld), 32'h0);
    chk("arst_off", 32'(mode_off), 32'h1);
    cycle(3'b001, 4'($urandom), 4'($urandom), 4'($urandom));
    irstb = 1'b1;
    cycle(3'b001, 4'($urandom), 4'($urandom), 4'h0);
    pat1 = 8'hC3;
    for (int c = 0; c < 4; c++) cycle(3'b001, {3'h0, pat1[2*c]}, {3'h0, pat1[2*c+1]}, 4'h0);
    chk("arst_c3", 32'(dout[7:0]), 32'hC3);

    // Randomized traffic against the model
    begin
      logic [2:0] rx;
      logic [2:0] modes [5];
      modes = '{3'b001, 3'b100, 3'b010, 3'b000, 3'b111};
      rx = 3'b001;
      for (int c = 0; c < 600; c++) begin
        logic [NLANE-1:0] sl;
        if ($urandom_range(0, 24) == 0) rx = modes[$urandom_range(0, 4)];
        for (int i = 0; i < NLANE; i++) sl[i] = ($urandom_range(0, 7) == 0);
        cycle(rx, 4'($urandom), 4'($urandom), sl);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
